// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage execute unit: FSM states, decode codes, funct3 values.
package alu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_SHIFT,
    ST_MUL,
    ST_DONE
  } state_t;

  localparam logic [1:0] CTRL_ADDR   = 2'b00;
  localparam logic [1:0] CTRL_ARITH  = 2'b01;
  localparam logic [1:0] CTRL_BRANCH = 2'b10;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_MUL  = 3'b000;

  localparam int OP_MEXT = 3;
  localparam int BR_REL  = 1;
  localparam int BR_UNS  = 0;

  function automatic logic is_shift_op(input logic [1:0] ctrl, input logic [3:0] op);
    return (ctrl == CTRL_ARITH) && !op[OP_MEXT] && (op[2:0] == F3_SLL || op[2:0] == F3_SR);
  endfunction

  function automatic logic is_mul_op(input logic [1:0] ctrl, input logic [3:0] op);
    return (ctrl == CTRL_ARITH) && op[OP_MEXT] && (op[2:0] == F3_MUL);
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operand/decode request and result response channels of the execute unit.
interface alu_exec_unit_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      control;
  logic [3:0]      alu_op;
  logic            flag;
  logic            eq;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            taken;

  modport master (
    output in_valid, control, alu_op, flag, eq, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, taken
  );

  modport slave (
    input  in_valid, control, alu_op, flag, eq, op_a, op_b, out_ready,
    output in_ready, out_valid, result, taken
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, MUL_STEP multiplier bits per cycle; done pulses
// XLEN/MUL_STEP cycles after start, prod holds the low XLEN product bits until the next start.
module alu_mul_iter #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] prod
);
  localparam int STEPS = XLEN / MUL_STEP;
  localparam int CW    = $clog2(STEPS + 1);

  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc_next;
  logic [CW-1:0]   cnt;
  logic            busy;

  always_comb begin
    acc_next = prod;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (mplier[i]) acc_next = acc_next + (mcand << i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mcand  <= a;
        mplier <= b;
        prod   <= '0;
        cnt    <= CW'(STEPS);
        busy   <= 1'b1;
      end else if (busy) begin
        prod   <= acc_next;
        mcand  <= mcand << MUL_STEP;
        mplier <= mplier >> MUL_STEP;
        cnt    <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage execute unit: one op in flight; simple ops 1 cycle, shifts 1+shamt, MUL 1+XLEN/MUL_STEP.
// in_ready only while idle; result held with out_valid until out_ready is seen.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input logic           clk,
  input logic           rst,
  alu_exec_unit_if.slave bus
);
  localparam int SHW = $clog2(XLEN);

  state_t          state;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [1:0]      ctrl_q;
  logic [3:0]      op_q;
  logic            flag_q;
  logic            eq_q;
  logic [SHW-1:0]  cnt;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [XLEN-1:0] result_q;
  logic            taken_q;

  logic [XLEN-1:0] res_c;
  logic            taken_c;
  logic [XLEN-1:0] sh_next;
  logic            mul_start;
  logic            mul_done;
  logic [XLEN-1:0] mul_prod;

  assign mul_start = bus.in_valid & in_ready_q & is_mul_op(bus.control, bus.alu_op);

  alu_mul_iter #(.XLEN(XLEN), .MUL_STEP(MUL_STEP)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (bus.op_a),
    .b     (bus.op_b),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_comb begin
    res_c   = '0;
    taken_c = 1'b0;
    case (ctrl_q)
      CTRL_ARITH: begin
        if (!op_q[OP_MEXT]) begin
          case (op_q[2:0])
            F3_ADD:  res_c = flag_q ? (a_q - b_q) : (a_q + b_q);
            F3_SLT:  res_c = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            F3_SLTU: res_c = {{(XLEN-1){1'b0}}, (a_q < b_q)};
            F3_XOR:  res_c = a_q ^ b_q;
            F3_OR:   res_c = a_q | b_q;
            F3_AND:  res_c = a_q & b_q;
            default: res_c = '0;
          endcase
        end
      end
      CTRL_BRANCH: begin
        if (flag_q) taken_c = eq_q ^ (a_q == b_q);
        else if (op_q[BR_UNS]) taken_c = eq_q ^ (a_q >= b_q);
        else taken_c = eq_q ^ ($signed(a_q) >= $signed(b_q));
      end
      default: res_c = a_q + b_q;
    endcase
  end

  // a_q doubles as the shift register; the sign bit never moves on a right shift, giving SRA fill.
  always_comb begin
    sh_next = a_q >> 1;
    if (op_q[2:0] == F3_SLL) sh_next = a_q << 1;
    else if (flag_q) sh_next = {a_q[XLEN-1], a_q[XLEN-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      ctrl_q      <= '0;
      op_q        <= '0;
      flag_q      <= 1'b0;
      eq_q        <= 1'b0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      taken_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.op_a;
            b_q        <= bus.op_b;
            ctrl_q     <= bus.control;
            op_q       <= bus.alu_op;
            flag_q     <= bus.flag;
            eq_q       <= bus.eq;
            cnt        <= bus.op_b[SHW-1:0];
            in_ready_q <= 1'b0;
            if (is_mul_op(bus.control, bus.alu_op)) state <= ST_MUL;
            else if (is_shift_op(bus.control, bus.alu_op)) state <= ST_SHIFT;
            else state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result_q    <= res_c;
          taken_q     <= taken_c;
          out_valid_q <= 1'b1;
          state       <= ST_DONE;
        end
        ST_SHIFT: begin
          if (cnt == '0) begin
            result_q    <= a_q;
            taken_q     <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= ST_DONE;
          end else begin
            a_q <= sh_next;
            cnt <= cnt - 1'b1;
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            result_q    <= mul_prod;
            taken_q     <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.taken     = taken_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with an independent reference model and per-cycle monitor.
module tb_alu_exec_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_exec_unit_if #(.XLEN(32)) bus ();
  alu_exec_unit #(.XLEN(32), .MUL_STEP(1)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] res;
    logic        tk;
    int          lat;
    int          acc;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: outputs and latency straight from the decode rules.
  function automatic exp_t model(input logic [1:0] c, input logic [3:0] op, input logic f,
                                 input logic e, input logic [31:0] a, input logic [31:0] b);
    exp_t x;
    int sh;
    sh    = int'(b[4:0]);
    x.res = 32'd0;
    x.tk  = 1'b0;
    x.lat = 1;
    x.acc = 0;
    if (c == 2'b01) begin
      if (op[3]) begin
        x.res = (op[2:0] == 3'd0) ? a * b : 32'd0;
        x.lat = (op[2:0] == 3'd0) ? 33 : 1;
      end else begin
        case (op[2:0])
          3'd0: x.res = f ? a - b : a + b;
          3'd1: begin x.res = a << sh; x.lat = 1 + sh; end
          3'd2: x.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3'd3: x.res = (a < b) ? 32'd1 : 32'd0;
          3'd4: x.res = a ^ b;
          3'd5: begin x.res = f ? 32'($signed(a) >>> sh) : a >> sh; x.lat = 1 + sh; end
          3'd6: x.res = a | b;
          default: x.res = a & b;
        endcase
      end
    end else if (c == 2'b10) begin
      if (f) x.tk = e ^ (a == b);
      else if (op[0]) x.tk = e ^ (a >= b);
      else x.tk = e ^ ($signed(a) >= $signed(b));
    end else begin
      x.res = a + b;
    end
    return x;
  endfunction

  // Per-cycle monitor: detects accepts/handshakes itself and checks against the model.
  exp_t q[$];
  exp_t cur;
  exp_t nx;
  bit   active   = 1'b0;
  bit   inflight = 1'b0;
  bit   prev_ir  = 1'b1;
  bit   prev_ov  = 1'b0;
  int   cyc      = 0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      q.delete();
      active   = 1'b0;
      inflight = 1'b0;
    end else begin
      if (prev_ov && bus.out_ready) begin
        inflight = 1'b0;
        active   = 1'b0;
      end
      if (prev_ir && bus.in_valid) begin
        nx     = model(bus.control, bus.alu_op, bus.flag, bus.eq, bus.op_a, bus.op_b);
        nx.acc = cyc;
        q.push_back(nx);
        inflight = 1'b1;
      end
      chk("mon_in_ready", 32'(bus.in_ready), 32'(!inflight));
      if (bus.out_valid) begin
        if (!active) begin
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL mon_unexpected: out_valid=1 with no op pending, result=0x%08h", bus.result);
          end else begin
            cur    = q.pop_front();
            active = 1'b1;
            chk("mon_latency", 32'(cyc - cur.acc), 32'(cur.lat));
            chk("mon_result", bus.result, cur.res);
            chk("mon_taken", 32'(bus.taken), 32'(cur.tk));
          end
        end else begin
          chk("mon_hold_result", bus.result, cur.res);
          chk("mon_hold_taken", 32'(bus.taken), 32'(cur.tk));
        end
      end else if (q.size() > 0 && (cyc - q[0].acc) > q[0].lat) begin
        tests++;
        fails++;
        $display("FAIL mon_timeout: no out_valid %0d cycles after accept, required %0d", cyc - q[0].acc, q[0].lat);
        void'(q.pop_front());
      end
    end
    prev_ir = bus.in_ready;
    prev_ov = bus.out_valid;
  end

  task automatic do_op(input string nm, input logic [1:0] c, input logic [3:0] op,
                       input logic f, input logic e, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic exp_tk, input int exp_lat,
                       input int hold, input bit pulse);
    int n;
    @(negedge clk);
    bus.control   = c;
    bus.alu_op    = op;
    bus.flag      = f;
    bus.eq        = e;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    chk({nm, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: out_valid=0 after %0d cycles, required 1 after %0d", nm, n, exp_lat);
    end else begin
      chk({nm, "_lat"}, 32'(n), 32'(exp_lat));
      chk({nm, "_result"}, bus.result, exp_res);
      chk({nm, "_taken"}, 32'(bus.taken), 32'(exp_tk));
    end
    for (int i = 0; i < hold; i++) begin
      if (pulse) begin
        bus.in_valid = (i % 2 == 0);
        bus.control  = 2'b00;
        bus.op_a     = 32'h1234_0000 + 32'(i);
      end
      @(negedge clk);
      chk({nm, "_bp_result"}, bus.result, exp_res);
      chk({nm, "_bp_in_ready"}, 32'(bus.in_ready), 32'd0);
      chk({nm, "_bp_out_valid"}, 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({nm, "_release_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({nm, "_release_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  exp_t m;

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.control   = 2'b00;
    bus.alu_op    = 4'd0;
    bus.flag      = 1'b0;
    bus.eq        = 1'b0;
    bus.op_a      = 32'd0;
    bus.op_b      = 32'd0;
    #2 rst = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_taken", 32'(bus.taken), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    m = model(2'b01, 4'b0101, 1'b1, 1'b0, 32'h8000_0000, 32'd4);
    chk("model_sra_res", m.res, 32'hF800_0000);
    chk("model_sra_lat", 32'(m.lat), 32'd5);
    m = model(2'b01, 4'b1000, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd3);
    chk("model_mul_res", m.res, 32'hFFFF_FFFD);
    m = model(2'b10, 4'b0010, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1);
    chk("model_blt_tk", 32'(m.tk), 32'd1);

    //    name        ctrl   op       f     e     a             b             result        tk    lat
    do_op("add",      2'b01, 4'b0000, 1'b0, 1'b0, 32'd5,        32'd7,        32'd12,       1'b0, 1,  0, 0);
    do_op("sub",      2'b01, 4'b0000, 1'b1, 1'b0, 32'd5,        32'd7,        32'hFFFF_FFFE, 1'b0, 1, 0, 0);
    do_op("slt",      2'b01, 4'b0010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,       32'd1,        1'b0, 1,  0, 0);
    do_op("sltu",     2'b01, 4'b0011, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,       32'd0,        1'b0, 1,  0, 0);
    do_op("xor",      2'b01, 4'b0100, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1, 0, 0);
    do_op("or",       2'b01, 4'b0110, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1, 0, 0);
    do_op("and",      2'b01, 4'b0111, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1, 0, 0);
    do_op("sra",      2'b01, 4'b0101, 1'b1, 1'b0, 32'h8000_0000, 32'd4,       32'hF800_0000, 1'b0, 5, 0, 0);
    do_op("srl",      2'b01, 4'b0101, 1'b0, 1'b0, 32'h8000_0000, 32'd4,       32'h0800_0000, 1'b0, 5, 0, 0);
    do_op("sll0",     2'b01, 4'b0001, 1'b0, 1'b0, 32'd3,        32'd0,        32'd3,        1'b0, 1,  0, 0);
    do_op("sll31",    2'b01, 4'b0001, 1'b0, 1'b0, 32'd1,        32'd31,       32'h8000_0000, 1'b0, 32, 0, 0);
    do_op("sra_hib",  2'b01, 4'b0101, 1'b1, 1'b0, 32'hF000_0000, 32'h24,      32'hFF00_0000, 1'b0, 5, 0, 0);
    do_op("mul",      2'b01, 4'b1000, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd3,       32'hFFFF_FFFD, 1'b0, 33, 0, 0);
    do_op("mdiv",     2'b01, 4'b1100, 1'b0, 1'b0, 32'd10,       32'd3,        32'd0,        1'b0, 1,  0, 0);
    do_op("blt",      2'b10, 4'b0010, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1,       32'd0,        1'b1, 1,  0, 0);
    do_op("bgeu",     2'b10, 4'b0011, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,       32'd0,        1'b1, 1,  0, 0);
    do_op("bne",      2'b10, 4'b0000, 1'b1, 1'b1, 32'd9,        32'd9,        32'd0,        1'b0, 1,  0, 0);
    do_op("beq",      2'b10, 4'b0000, 1'b1, 1'b0, 32'd9,        32'd9,        32'd0,        1'b1, 1,  0, 0);
    do_op("addr00",   2'b00, 4'b0000, 1'b0, 1'b0, 32'd100,      32'hFFFF_FFFC, 32'd96,      1'b0, 1,  0, 0);
    do_op("addr11",   2'b11, 4'b0111, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1,       32'd0,        1'b0, 1,  0, 0);
    do_op("bp_add",   2'b01, 4'b0000, 1'b0, 1'b0, 32'd20,       32'd22,       32'd42,       1'b0, 1,  5, 1);

    // Abort a multiply ten cycles in; no result may ever appear for it.
    @(negedge clk);
    bus.control  = 2'b01;
    bus.alu_op   = 4'b1000;
    bus.flag     = 1'b0;
    bus.eq       = 1'b0;
    bus.op_a     = 32'd7;
    bus.op_b     = 32'd6;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_result", bus.result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op("add_after_rst", 2'b01, 4'b0000, 1'b0, 1'b0, 32'd2, 32'd2, 32'd4, 1'b0, 1, 0, 0);
    repeat (40) @(negedge clk);
    chk("idle_out_valid", 32'(bus.out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
